updown_counter_param: RTL
=========================

# updown_counter_param

Parametrised up/down counter: next-generation replacement for the fixed 8-bit counter. It adds configurable width and modulo limit, a programmable step, parallel load, wrap or saturate mode, and separate overflow/underflow pulses with sticky status. It is used as the generic event/position counter in datapath and control blocks, with its own directed testbench.

## Interface
- WIDTH, 8: counter width in bits; 2 ≤ WIDTH ≤ 32.
- MAX_COUNT, 2**WIDTH-1: modulo limit, inclusive; count range is 0..MAX_COUNT; 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the limits; 1 = clamp at 0 / MAX_COUNT.
- RESET_VALUE, 0: count value after reset; must be ≤ MAX_COUNT.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  count enable.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  WIDTH  increment/decrement amount; effective step = min(step, MAX_COUNT).
- load  in  1  synchronous parallel load.
- load_value  in  WIDTH  load data; values > MAX_COUNT load as MAX_COUNT.
- clear_flags  in  1  clears sticky flags.
- count  out  WIDTH  registered count.
- overflow  out  1  registered one-cycle pulse: an up step crossed MAX_COUNT.
- underflow  out  1  registered one-cycle pulse: a down step crossed 0.
- ovf_sticky  out  1  set by overflow; held until clear_flags or rst.
- udf_sticky  out  1  set by underflow; held until clear_flags or rst.
- at_max  out  1  combinational: count == MAX_COUNT.
- at_min  out  1  combinational: count == 0.

## Operation
- One clock, synchronous active-high reset (rst).
- Reset values: count = RESET_VALUE; overflow, underflow, ovf_sticky and udf_sticky = 0.
- Per-edge priority: rst > load > enable > hold.
- load: count ← clamped load_value. No overflow/underflow pulse is generated. Sticky flags are unaffected.
- enable = 0 and no load: count holds; pulses go to 0.
- Arithmetic uses WIDTH+1-bit intermediates. s = effective step.
- Up, count + s ≤ MAX_COUNT: count ← count + s.
- Up, count + s > MAX_COUNT:
  - wrap: count ← count + s − (MAX_COUNT+1).
  - saturate: count ← MAX_COUNT.
  - Either mode: overflow = 1.
- Down, count ≥ s: count ← count − s.
- Down, count < s:
  - wrap: count ← count + (MAX_COUNT+1) − s.
  - saturate: count ← 0.
  - Either mode: underflow = 1.
- Saturate mode at a limit: stepping further keeps count at the limit and pulses overflow/underflow on every enabled cycle.
- s = 0 with enable: count holds; no pulse.
- Sticky flags:
  - Set on the same edge as their pulse.
  - clear_flags clears them.
  - A pulse and clear_flags on the same edge: set wins.
- up_down changing between cycles takes effect on the next enabled edge; no dead cycle.

## Timing
- All state changes on the rising clk edge.
- count, overflow and underflow are updated on the same edge. A pulse is high for exactly the cycle in which count shows the wrapped or clamped value.
- Load latency: 1 cycle. Step latency: 1 cycle.
- at_max and at_min follow count combinationally (zero latency after count).
- rst asserted mid-count: the next edge gives count = RESET_VALUE and all flags 0, regardless of load or enable.
- Releasing rst: counting resumes on the first edge with rst = 0 and enable = 1.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=0x10, run to 0x35, assert rst for 1 cycle with enable=1 → count=0x10 on the next edge; pulses and sticky flags 0.
- Wrap up: defaults, load 0xFD, enable, up, step=1 → count 0xFE, 0xFF, 0x00. overflow is high only in the 0x00 cycle; ovf_sticky stays 1; at_max is high in the 0xFF cycle.
- Wrap down with step: MAX_COUNT=9 (WIDTH=4), load 2, down, step=3 → count 9 with underflow=1, then 6, 3, 0, then 7 with underflow=1.
- Saturate: SATURATE=1, load 0xFE, up, step=5 → count 0xFF with overflow=1, then stays 0xFF with overflow=1 every enabled cycle. Then down, step=0x10 → 0xEF, no pulse.
- Enable/load priority: enable=0 at count 0x03 for 3 cycles → holds 0x03. load=1, load_value=0x80 with enable=1, up → 0x80 (no increment). load_value=0xC8 with MAX_COUNT=100 → count=100, no pulse.
- Sticky clear: with ovf_sticky=1, drive clear_flags on the same edge as a new overflow → ovf_sticky stays 1. clear_flags on a later idle cycle → 0.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with step, load, wrap/saturate and sticky flags
module updown_counter_param #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT   = '1,
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             ovf_sticky,
  output logic             udf_sticky,
  output logic             at_max,
  output logic             at_min
);
  logic [WIDTH-1:0] count_q, count_d, s, ld;
  logic [WIDTH:0] sum_w;
  logic up_ovf, dn_udf;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
  // Wrapped results use modulo-2^WIDTH arithmetic: adding ~MAX_COUNT equals subtracting MAX_COUNT+1.
  always_comb begin
    s = (step > MAX_COUNT) ? MAX_COUNT : step;
    ld = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
    sum_w = {1'b0, count_q} + {1'b0, s};
    up_ovf = sum_w > {1'b0, MAX_COUNT};
    dn_udf = count_q < s;
    count_d = count_q;
    overflow_d = 1'b0;
    underflow_d = 1'b0;
    if (load) count_d = ld;
    else if (enable && up_down) begin
      count_d = !up_ovf ? count_q + s : SATURATE ? MAX_COUNT : count_q + s + ~MAX_COUNT;
      overflow_d = up_ovf;
    end else if (enable) begin
      count_d = !dn_udf ? count_q - s : SATURATE ? '0 : count_q - s - ~MAX_COUNT;
      underflow_d = dn_udf;
    end
    ovf_sticky_d = overflow_d | (ovf_sticky_q & ~clear_flags);
    udf_sticky_d = underflow_d | (udf_sticky_q & ~clear_flags);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VALUE;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      count_q <= count_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end
  assign count = count_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  assign ovf_sticky = ovf_sticky_q;
  assign udf_sticky = udf_sticky_q;
  assign at_max = count_q == MAX_COUNT;
  assign at_min = count_q == '0;
endmodule
